// File: rtl/p_div.sv
// p_div: iterative packed unsigned divider, one quotient bit per cycle in every lane.
// Lane width is picked per operation by the one-hot pw (32/16/8/4/2). All lane widths
// compute their next step in parallel; the selected width's result is latched.

// One restoring-division step for a single lane of width W.
module p_div_lane #(
    parameter int W = 8
) (
    input  logic [W-1:0] src,    // dividend bits still to shift out
    input  logic [W-1:0] racc,   // partial remainder
    input  logic [W-1:0] d,      // divisor
    output logic [W-1:0] quo_n,
    output logic [W-1:0] rmd_n
);
    logic [W:0]   s;
    logic [W+1:0] t;
    logic         unused_hi;

    // Trial subtract at W+1 bits so 2*rmd+bit never overflows before the compare.
    always_comb begin
        s         = {racc, src[W-1]};
        t         = {1'b0, s} - {2'b00, d};
        quo_n     = {src[W-2:0], ~t[W+1]};
        rmd_n     = t[W+1] ? s[W-1:0] : t[W-1:0];
        unused_hi = t[W] ^ s[W];
    end
endmodule

module p_div (
    input  logic        clock,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic        div,
    input  logic        rem,
    input  logic [4:0]  pw,
    input  logic [31:0] crs1,
    input  logic [31:0] crs2,
    output logic [31:0] result
);
    logic [5:0]       count_q, count_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      rmd_q, rmd_d;
    logic [5:0]       w;
    logic [2:0]       sel;
    logic             first;
    logic             step;
    logic [31:0]      src, racc;
    logic [4:0][31:0] nq, nr;
    logic             unused_div;

    // Lane width decode; priority keeps a multi-hot pw bounded to 32 steps.
    always_comb begin
        w   = 6'd0;
        sel = 3'd0;
        if      (pw[0]) begin w = 6'd32; sel = 3'd0; end
        else if (pw[1]) begin w = 6'd16; sel = 3'd1; end
        else if (pw[2]) begin w = 6'd8;  sel = 3'd2; end
        else if (pw[3]) begin w = 6'd4;  sel = 3'd3; end
        else if (pw[4]) begin w = 6'd2;  sel = 3'd4; end
    end

    assign first = (count_q == 6'd0);
    assign src   = first ? crs1 : quo_q;
    assign racc  = first ? 32'd0 : rmd_q;

    // One array of lane steppers per supported lane width.
    for (genvar g = 0; g < 5; g++) begin : g_width
        localparam int W = 32 >> g;
        for (genvar l = 0; l < 32 / W; l++) begin : g_lane
            p_div_lane #(.W(W)) u_lane (
                .src   (src[l*W +: W]),
                .racc  (racc[l*W +: W]),
                .d     (crs2[l*W +: W]),
                .quo_n (nq[g][l*W +: W]),
                .rmd_n (nr[g][l*W +: W])
            );
        end
    end

    assign step  = valid && (count_q < w);
    assign ready = resetn && valid && (count_q == w);

    // Sequencing: step while count<W, restart after ready, drop partial state on abort.
    always_comb begin
        count_d = count_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        if (!valid || ready) begin
            count_d = 6'd0;
        end else if (step) begin
            count_d = count_q + 6'd1;
            quo_d   = nq[sel];
            rmd_d   = nr[sel];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            count_q <= 6'd0;
            quo_q   <= 32'd0;
            rmd_q   <= 32'd0;
        end else begin
            count_q <= count_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
        end
    end

    // div is implied by !rem; only rem steers the output mux.
    assign unused_div = div;
    assign result     = (w == 6'd0) ? 32'd0 : (rem ? rmd_q : quo_q);
endmodule

// File: tb/tb_p_div.sv
// Directed and randomized bench for p_div against a naive per-lane division model.
module tb_p_div;
    logic        clock = 1'b0;
    logic        resetn, valid, ready, div, rem;
    logic [4:0]  pw;
    logic [31:0] crs1, crs2, result;
    int          nvec = 0;
    int          nerr = 0;

    p_div dut (
        .clock  (clock),
        .resetn (resetn),
        .valid  (valid),
        .ready  (ready),
        .div    (div),
        .rem    (rem),
        .pw     (pw),
        .crs1   (crs1),
        .crs2   (crs2),
        .result (result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wl(input logic [4:0] p);
        if (p[0]) return 32;
        if (p[1]) return 16;
        if (p[2]) return 8;
        if (p[3]) return 4;
        if (p[4]) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] model(input logic [4:0] p, input logic [31:0] a,
                                          input logic [31:0] b, input logic r);
        int                w;
        longint unsigned   m, av, bv, q, rr, acc;
        w   = wl(p);
        acc = 0;
        if (w == 0) return 32'd0;
        m = (64'd1 << w) - 1;
        for (int l = 0; l < 32 / w; l++) begin
            av = (longint'(a) >> (l * w)) & m;
            bv = (longint'(b) >> (l * w)) & m;
            if (bv == 0) begin q = m; rr = av; end
            else begin q = av / bv; rr = av % bv; end
            acc = acc | ((r ? rr : q) << (l * w));
        end
        return acc[31:0];
    endfunction

    // Starts an op on the next negedge, leaves valid high after ready is seen.
    task automatic run_op(input logic [4:0] p, input logic r, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output int lat);
        @(negedge clock);
        resetn = 1'b1;
        valid  = 1'b1;
        pw     = p;
        div    = !r;
        rem    = r;
        crs1   = a;
        crs2   = b;
        lat    = 1;
        #1;
        while (!ready && lat < 40) begin
            @(negedge clock);
            lat++;
            #1;
        end
        res = result;
    endtask

    task automatic do_op(input string tag, input logic [4:0] p, input logic r,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int explat);
        logic [31:0] res;
        int          lat;
        run_op(p, r, a, b, res, lat);
        chk(tag, res, exp);
        chk({tag, ".lat"}, lat, explat);
    endtask

    task automatic idle();
        @(negedge clock);
        valid = 1'b0;
    endtask

    initial begin
        logic [4:0]  pws [5];
        logic [4:0]  p;
        logic [31:0] a, b;
        logic        r;
        pws = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

        resetn = 1'b0; valid = 1'b0; div = 1'b0; rem = 1'b0;
        pw = 5'd1; crs1 = 32'd0; crs2 = 32'd0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst.ready", {31'd0, ready}, 32'd0);
        chk("rst.quo", result, 32'd0);
        rem = 1'b1;
        #1;
        chk("rst.rmd", result, 32'd0);

        // pw==0: immediate ready, zero result
        do_op("pw0", 5'd0, 1'b0, 32'h1234_5678, 32'd3, 32'd0, 1);
        idle();

        do_op("t1.div", 5'b00001, 1'b0, 32'd100, 32'd7, 32'd14, 33);
        idle();
        @(negedge clock);
        #1;
        chk("t1.pulse", {31'd0, ready}, 32'd0);
        do_op("t1.rem", 5'b00001, 1'b1, 32'd100, 32'd7, 32'd2, 33);
        idle();
        do_op("t1.ovf.q", 5'b00001, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
        idle();
        do_op("t1.ovf.r", 5'b00001, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);
        idle();

        do_op("t2.div", 5'b00100, 1'b0, 32'hFF64_0A07, 32'h1007_0302, 32'h0F0E_0303, 9);
        idle();
        do_op("t2.rem", 5'b00100, 1'b1, 32'hFF64_0A07, 32'h1007_0302, 32'h0F02_0101, 9);
        idle();

        do_op("t3.div", 5'b00010, 1'b0, 32'h1234_5678, 32'h0000_0001, 32'hFFFF_5678, 17);
        idle();
        do_op("t3.rem", 5'b00010, 1'b1, 32'h1234_5678, 32'h0000_0001, 32'h1234_0000, 17);
        idle();

        do_op("t4.div", 5'b10000, 1'b0, 32'hFFFF_FFFF, 32'h5555_5555, 32'hFFFF_FFFF, 3);
        idle();
        do_op("t4.rem", 5'b10000, 1'b1, 32'hFFFF_FFFF, 32'h5555_5555, 32'd0, 3);
        idle();

        // pw=4 exhaustive over nibble pairs, back-to-back
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int k = 0; k < 2; k++) begin
                    a = {8{i[3:0]}} ^ 32'h0123_4567;
                    b = {8{j[3:0]}};
                    r = k[0];
                    do_op("sweep4", 5'b01000, r, a, b, model(5'b01000, a, b, r), 5);
                end
            end
        end
        idle();

        // abort by dropping valid at count 5
        @(negedge clock);
        valid = 1'b1; pw = 5'b00001; div = 1'b1; rem = 1'b0;
        crs1 = 32'd100; crs2 = 32'd7;
        repeat (5) @(negedge clock);
        valid = 1'b0;
        do_op("abort.q", 5'b00001, 1'b0, 32'd200, 32'd9, 32'd22, 33);
        idle();
        do_op("abort.r", 5'b00001, 1'b1, 32'd200, 32'd9, 32'd2, 33);
        idle();

        // abort by reset pulse with valid held high
        @(negedge clock);
        valid = 1'b1; pw = 5'b00001; div = 1'b1; rem = 1'b0;
        crs1 = 32'd100; crs2 = 32'd7;
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("rstab.ready", {31'd0, ready}, 32'd0);
        do_op("rstab.q", 5'b00001, 1'b0, 32'd200, 32'd9, 32'd22, 33);
        idle();

        // back-to-back with valid held across ready
        do_op("b2b.16", 5'b00010, 1'b0, 32'hABCD_1234, 32'h0013_0007,
              model(5'b00010, 32'hABCD_1234, 32'h0013_0007, 1'b0), 17);
        do_op("b2b.8", 5'b00100, 1'b1, 32'hC8FF_3310, 32'h0B10_0705,
              model(5'b00100, 32'hC8FF_3310, 32'h0B10_0705, 1'b1), 9);
        idle();

        // randomized ops against the model
        for (int n = 0; n < 1500; n++) begin
            p = pws[$urandom_range(0, 4)];
            r = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = $urandom & 32'h0F0F_00FF;
            do_op("rand", p, r, a, b, model(p, a, b, r), wl(p) + 1);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
